// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Bundles the switch bank, the two buttons and the result/flag outputs of the
// sequenced ALU execution stage.
//   master : drives i_sw, i_btn_load, i_btn_clear; observes the results
//   slave  : the alu_seq block itself
// Signals
//   i_sw        [SW_W-1:0]   switch bank (operands and opcode)
//   i_btn_load               load/advance button
//   i_btn_clear              abort/clear button
//   o_res       [DATA_W-1:0] signed registered result
//   o_carry                  carry (ADD) / borrow (SUB)
//   o_zero                   result == 0
//   o_ovf                    signed overflow (ADD/SUB)
//   o_valid                  result/flags hold a completed result
//   o_state     [2:0]        current sequencer state
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6,
  parameter int SW_W   = 8
);
  logic [SW_W-1:0]          i_sw;
  logic                     i_btn_load;
  logic                     i_btn_clear;
  logic signed [DATA_W-1:0] o_res;
  logic                     o_carry;
  logic                     o_zero;
  logic                     o_ovf;
  logic                     o_valid;
  logic [2:0]               o_state;

  modport master (
    output i_sw, i_btn_load, i_btn_clear,
    input  o_res, o_carry, o_zero, o_ovf, o_valid, o_state
  );

  modport slave (
    input  i_sw, i_btn_load, i_btn_clear,
    output o_res, o_carry, o_zero, o_ovf, o_valid, o_state
  );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequenced ALU execution stage. Operand A, operand B and the opcode are loaded
// one after another from a single switch bank with the load button; a dedicated
// EXEC cycle registers the result and flags, which are then held with a valid
// strobe until the next load. A clear button aborts and zeroes everything.
//
// Ports
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        alu_seq_if.slave: i_sw, i_btn_load, i_btn_clear in;
//              o_res, o_carry, o_zero, o_ovf, o_valid, o_state out
//
// Build option
//   ALU_SEQ_BTN_EDGE_EN  defined: buttons are rising-edge detected (one event
//                        per press). Undefined: the button level is the event,
//                        so a held load advances one state per cycle.
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6,
  parameter int SW_W   = 8
) (
  input  logic      i_clock,
  input  logic      i_reset_n,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);

  // Shift amounts at or above this limit flush the operand completely.
  localparam logic [DATA_W:0] SHIFT_LIM = (DATA_W+1)'(DATA_W);

  // Returns {result, carry, ovf}; zero is derived from the result by the caller.
  function automatic logic [DATA_W+1:0] alu_calc(
    input logic [OP_W-1:0]          op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W:0]          wide;
    logic signed [DATA_W-1:0] res;
    logic                     carry;
    logic                     ovf;
    logic                     big_shift;
    wide      = '0;
    res       = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    big_shift = ({1'b0, b} >= SHIFT_LIM);
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = signed'(wide[DATA_W-1:0]);
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        // The borrow out of the extended subtraction is exactly A < B unsigned.
        wide  = {1'b0, a} - {1'b0, b};
        res   = signed'(wide[DATA_W-1:0]);
        carry = wide[DATA_W];
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRL: res = big_shift ? '0 : signed'($unsigned(a) >> $unsigned(b));
      OP_SRA: res = big_shift ? {DATA_W{a[DATA_W-1]}} : (a >>> $unsigned(b));
      default: res = '0;
    endcase
    return {res, carry, ovf};
  endfunction

  state_t                   state;
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [OP_W-1:0]          op_p0;
  logic signed [DATA_W-1:0] res_p1;
  logic                     carry_p1;
  logic                     zero_p1;
  logic                     ovf_p1;
  logic                     vld_p1;
  logic                     load_ev;
  logic                     clear_ev;
  logic [DATA_W+1:0]        alu_out;

`ifdef ALU_SEQ_BTN_EDGE_EN
  logic load_q;
  logic clear_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      load_q  <= bus.i_btn_load;
      clear_q <= bus.i_btn_clear;
    end
  end

  assign load_ev  = bus.i_btn_load  & ~load_q;
  assign clear_ev = bus.i_btn_clear & ~clear_q;
`else
  assign load_ev  = bus.i_btn_load;
  assign clear_ev = bus.i_btn_clear;
`endif

  // ---- operand stage (p0) -> execute stage (p1) ----
  always_comb begin
    alu_out = alu_calc(op_p0, a_p0, b_p0);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= WAIT_A;
      a_p0     <= '0;
      b_p0     <= '0;
      op_p0    <= '0;
      res_p1   <= '0;
      carry_p1 <= 1'b0;
      zero_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (clear_ev) begin
      state    <= WAIT_A;
      a_p0     <= '0;
      b_p0     <= '0;
      op_p0    <= '0;
      res_p1   <= '0;
      carry_p1 <= 1'b0;
      zero_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      case (state)
        WAIT_A: if (load_ev) begin
          a_p0  <= signed'(bus.i_sw[DATA_W-1:0]);
          state <= WAIT_B;
        end
        WAIT_B: if (load_ev) begin
          b_p0  <= signed'(bus.i_sw[DATA_W-1:0]);
          state <= WAIT_OP;
        end
        WAIT_OP: if (load_ev) begin
          op_p0 <= bus.i_sw[OP_W-1:0];
          state <= EXEC;
        end
        EXEC: begin
          // Load presses landing here are deliberately dropped.
          res_p1   <= signed'(alu_out[DATA_W+1:2]);
          carry_p1 <= alu_out[1];
          ovf_p1   <= alu_out[0];
          zero_p1  <= (alu_out[DATA_W+1:2] == '0);
          vld_p1   <= 1'b1;
          state    <= DONE;
        end
        DONE: if (load_ev) begin
          // Result and flags stay on display; only the strobe drops.
          a_p0   <= signed'(bus.i_sw[DATA_W-1:0]);
          vld_p1 <= 1'b0;
          state  <= WAIT_B;
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  assign bus.o_res   = res_p1;
  assign bus.o_carry = carry_p1;
  assign bus.o_zero  = zero_p1;
  assign bus.o_ovf   = ovf_p1;
  assign bus.o_valid = vld_p1;
  assign bus.o_state = state;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_seq_if #(.DATA_W(8), .OP_W(6), .SW_W(8)) bus ();

  alu_seq #(.DATA_W(8), .OP_W(6), .SW_W(8)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       carry;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  logic prev_vld = 1'b0;
  int   ops[8] = '{32, 34, 36, 37, 38, 39, 2, 3};

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic c, input logic z, input logic o);
    return {r, c, z, o};
  endfunction

  // Reference model: plain integer arithmetic on the values the operator entered.
  function automatic exp_t model(input int op_sw, input int a, input int b);
    int   op, sa, sb, r, s;
    logic c, o;
    op = op_sw & 63;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c  = 1'b0;
    o  = 1'b0;
    case (op)
      32: begin r = a + b; c = (r > 255); s = sa + sb; o = (s > 127) || (s < -128); end
      34: begin r = a - b; c = (a < b);   s = sa - sb; o = (s > 127) || (s < -128); end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = ~(a | b);
      2:  r = (b >= 8) ? 0 : (a >> b);
      3:  r = (b >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> b);
      default: r = 0;
    endcase
    r = r & 255;
    return mk(r[7:0], c, (r == 0), o);
  endfunction

  // Monitor: each rising of o_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && !prev_vld) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: o_res=0x%0h appeared, expected no result", $unsigned(bus.o_res));
      end else begin
        mon_e = sb_q.pop_front();
        chk("res",   int'($unsigned(bus.o_res)), int'(mon_e.res));
        chk("carry", int'(bus.o_carry), int'(mon_e.carry));
        chk("zero",  int'(bus.o_zero),  int'(mon_e.zero));
        chk("ovf",   int'(bus.o_ovf),   int'(mon_e.ovf));
      end
    end
    prev_vld <= bus.o_valid;
  end

  task automatic press(input logic [7:0] v);
    @(negedge clk);
    bus.i_sw       = v;
    bus.i_btn_load = 1'b1;
    @(negedge clk);
    bus.i_btn_load = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk);
    bus.i_btn_clear = 1'b1;
    @(negedge clk);
    bus.i_btn_clear = 1'b0;
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input exp_t e);
    press(a);
    press(b);
    sb_q.push_back(e);
    press(op);
    chk("exec_state", int'(bus.o_state), 3);
    chk("exec_valid_low", int'(bus.o_valid), 0);
    @(negedge clk);
    chk("done_state", int'(bus.o_state), 4);
    chk("done_valid", int'(bus.o_valid), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(bus.o_state), 0);
    chk({tag, "_res"},   int'($unsigned(bus.o_res)), 0);
    chk({tag, "_carry"}, int'(bus.o_carry), 0);
    chk({tag, "_zero"},  int'(bus.o_zero), 0);
    chk({tag, "_ovf"},   int'(bus.o_ovf), 0);
    chk({tag, "_valid"}, int'(bus.o_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, op, sel;
    bus.i_sw        = '0;
    bus.i_btn_load  = 1'b0;
    bus.i_btn_clear = 1'b0;
    rst_n           = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_seq(8'h7F, 8'h01, 8'h20, mk(8'h80, 1'b0, 1'b0, 1'b1));
    run_seq(8'h05, 8'h07, 8'h22, mk(8'hFE, 1'b1, 1'b0, 1'b0));
    run_seq(8'h80, 8'h09, 8'h03, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    run_seq(8'h80, 8'h09, 8'h02, mk(8'h00, 1'b0, 1'b1, 1'b0));
    run_seq(8'hF0, 8'h0F, 8'h27, mk(8'h00, 1'b0, 1'b1, 1'b0));
    run_seq(8'hF0, 8'h0F, 8'h3F, mk(8'h00, 1'b0, 1'b1, 1'b0));
    run_seq(8'hFF, 8'h01, 8'h20, mk(8'h00, 1'b1, 1'b1, 1'b0));
    run_seq(8'h80, 8'h01, 8'h22, mk(8'h7F, 1'b0, 1'b0, 1'b1));
    run_seq(8'h03, 8'h04, 8'hE0, mk(8'h07, 1'b0, 1'b0, 1'b0));
    run_seq(8'hC3, 8'h0F, 8'h26, mk(8'hCC, 1'b0, 1'b0, 1'b0));

    // Load and clear together in WAIT_OP: clear wins
    press(8'h11);
    press(8'h22);
    chk("wait_op_state", int'(bus.o_state), 2);
    chk("held_res_before_clear", int'($unsigned(bus.o_res)), 8'hCC);
    @(negedge clk);
    bus.i_sw        = 8'h20;
    bus.i_btn_load  = 1'b1;
    bus.i_btn_clear = 1'b1;
    @(negedge clk);
    bus.i_btn_load  = 1'b0;
    bus.i_btn_clear = 1'b0;
    chk_reset_outputs("clear");

    // Held load button
`ifdef ALU_SEQ_BTN_EDGE_EN
    @(negedge clk);
    bus.i_sw       = 8'h03;
    bus.i_btn_load = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_one_advance", int'(bus.o_state), 1);
    bus.i_btn_load = 1'b0;
    press_clear();
    chk("hold_cleared", int'(bus.o_state), 0);
`else
    sb_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    bus.i_sw       = 8'h03;
    bus.i_btn_load = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_btn_load = 1'b0;
    chk("hold_exec", int'(bus.o_state), 3);
    @(negedge clk);
    chk("hold_done", int'(bus.o_state), 4);
`endif

    // Asynchronous reset while in EXEC
    press(8'h7F);
    press(8'h01);
    press(8'h20);
    chk("pre_reset_exec", int'(bus.o_state), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(8'h40, 8'h40, 8'h20, mk(8'h80, 1'b0, 1'b0, 1'b1));

    // Randomized sequences
    for (int i = 0; i < 30; i++) begin
      a   = $urandom_range(0, 255);
      b   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      sel = $urandom_range(0, 9);
      if (sel < 8) op = ops[sel] | ($urandom_range(0, 3) << 6);
      else         op = $urandom_range(0, 255);
      run_seq(8'(a), 8'(b), 8'(op), model(op, a, b));
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("pending_results", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
